strzal_multi: RTL and testbench
===============================

Name: strzal_multi

Overview:
- Parametrised successor of the single-shot projectile overlay in the VGA pixel pipeline.
- Manages N_SHOTS independent projectiles. Each is launched on a mouse click from a fixed muzzle point toward the mouse position.
- Projectiles advance along a Bresenham line a fixed number of pixels per frame and are drawn as SIZE x SIZE squares over rgb_in.
- Sits between the background/target layer and the mouse-cursor layer. Passes timing signals through with matched latency.

Parameters:
- N_SHOTS, 4: number of projectile slots (1..8).
- START_X, 400: muzzle x coordinate.
- START_Y, 0: muzzle y coordinate.
- SPEED, 4: Bresenham steps per frame (1..15).
- SIZE, 4: square side in pixels.
- H_RES, 800: visible width; x >= H_RES is off-screen.
- V_RES, 600: visible height; y >= V_RES is off-screen.
- COLOR, 12'hf00: projectile colour.

Ports:
- clk  in  1  pixel clock, posedge.
- rst  in  1  synchronous, active-high reset.
- hcount_in  in  11  pixel x.
- vcount_in  in  11  pixel y.
- h_sync_in, v_sync_in, h_blank_in, v_blank_in  in  1 each  timing inputs.
- rgb_in  in  12  incoming pixel.
- x_pos_in, y_pos_in  in  12 each  mouse position, used as target.
- left_click  in  1  mouse button level.
- hit_in  in  N_SHOTS  per-slot hit/kill request from the collision block.
- hcount_out, vcount_out  out  11 each  delayed timing.
- h_sync_out, v_sync_out, h_blank_out, v_blank_out  out  1 each  delayed timing.
- rgb_out  out  12  pixel with projectiles overlaid.
- x_pos_out, y_pos_out  out  12 each  mouse position delayed 2 cycles.
- active_out  out  N_SHOTS  slot-in-flight flags.
- shot_x_out, shot_y_out  out  12*N_SHOTS each  packed slot positions; slot i occupies bits [12i+11:12i].

Behaviour:
- Reset: all slots IDLE with position, err and dx/dy cleared. Every output is 0, including rgb_out, active_out and shot positions. Reset during flight aborts all shots immediately.
- Latency: every pass-through and rgb_out is exactly 2 clk cycles behind its input.
  - Stage 1 registers the inputs and computes the hit-test.
  - Stage 2 produces the outputs.
- Click: rising edge of left_click, detected against a registered copy of the level.
  - A held button fires once.
  - The edge allocates the lowest-index IDLE slot.
  - If no slot is IDLE, the click is dropped with no other effect.
- Launch, in the edge cycle, for the allocated slot:
  - x = START_X, y = START_Y.
  - dx = |x_pos_in - START_X|, dy = |y_pos_in - START_Y|.
  - sx = +1 if x_pos_in >= START_X, else -1; sy likewise.
  - err = dx - dy, held as 14-bit signed.
  - State goes to FLY.
  - If dx = dy = 0, the slot goes to DONE instead.
- Frame tick: rising edge of v_blank_in.
  - The tick starts a step burst of SPEED consecutive clk cycles, counted by a 4-bit counter.
  - In each burst cycle, every slot that was in FLY when the tick occurred does one Bresenham step:
    - e2 = 2*err.
    - If e2 > -dy: err -= dy, x += sx.
    - If e2 < dx: err += dx, y += sy.
  - x and y are 12-bit unsigned. A decrement below 0 wraps to >= H_RES, which is off-screen.
  - A slot launched during a burst does not step until the next tick.
- States per slot (2-bit):
  - IDLE -> FLY on allocation.
  - FLY -> DONE when x >= H_RES, y >= V_RES, or hit_in[i] = 1. Evaluated every cycle; mid-burst exit halts further steps for that slot.
  - DONE -> IDLE after 1 cycle; position, err, dx and dy are cleared.
- Simultaneous events:
  - hit_in and a step in the same cycle: hit wins and the step is discarded.
  - Click edge and the tick in the same cycle: the launch happens and the new slot does not step this frame.
  - hit_in for an IDLE slot is ignored.
- Render: a pixel is inside slot i when:
  - state FLY, and
  - x <= hcount < x + SIZE, and
  - y <= vcount < y + SIZE.
  - Compare in 12 bits, with hcount and vcount zero-extended.
  - rgb_out = COLOR if any slot contains the pixel and both blanks are 0 (stage-1 values); otherwise rgb_out = rgb_in delayed.
- active_out[i] = 1 while slot i is in FLY. It is registered and updates 1 cycle after the state change.
- shot_x_out / shot_y_out show the registered x/y of each slot; IDLE slots read 0.

Test Plan:
- Reset mid-flight: launch 2 shots, assert rst for 1 cycle -> active_out = 0 and rgb_out = 0 next cycle; no overlay in the following frame.
- Vertical shot: mouse (400,300), single click, one tick with SPEED = 4 -> slot0 at (400,4); rgb_out = 12'hf00 at hcount 400..403, vcount 4..7; rgb_in passes elsewhere; latency 2 cycles.
- Diagonal and negative direction:
  - mouse (600,200) -> (404,4) after 1 frame and (408,8) after 2.
  - mouse (200,200) -> x decrements: (396,4).
- Slot allocation: N_SHOTS = 4, five click edges one frame apart -> slots 0..3 fill and the fifth click is dropped. Then hit_in = 4'b0010 -> slot1 DONE then IDLE; the next click takes slot1.
- Exit and edge cases:
  - mouse (799,0) -> x exceeds 799 after about 100 frames at SPEED 4; the slot frees.
  - mouse (400,0) -> dx = dy = 0, slot never shows active.
  - Click held 1000 cycles -> only one launch.
- Collisions of events:
  - hit_in[0] in the first burst cycle -> slot0 position unchanged, then cleared.
  - Click edge in the same cycle as the tick -> the new slot stays at (400,0) until the next frame.

Source files
------------

// File: rtl/strzal_multi_if.sv
// rtl/strzal_multi_if.sv - pixel/mouse/projectile bundle between the target layer and the cursor layer
// Ports (master drives *_in, left_click, hit_in; slave drives the *_out group):
//   hcount/vcount 11b, h/v sync and blank 1b, rgb 12b, x/y_pos 12b, left_click 1b,
//   hit_in N_SHOTS, active_out N_SHOTS, shot_x_out/shot_y_out 12*N_SHOTS (slot i at [12i+11:12i]).
interface strzal_multi_if #(
    parameter int N_SHOTS = 4
);
    logic [10:0]           hcount_in, vcount_in;
    logic                  h_sync_in, v_sync_in, h_blank_in, v_blank_in;
    logic [11:0]           rgb_in;
    logic [11:0]           x_pos_in, y_pos_in;
    logic                  left_click;
    logic [N_SHOTS-1:0]    hit_in;

    logic [10:0]           hcount_out, vcount_out;
    logic                  h_sync_out, v_sync_out, h_blank_out, v_blank_out;
    logic [11:0]           rgb_out;
    logic [11:0]           x_pos_out, y_pos_out;
    logic [N_SHOTS-1:0]    active_out;
    logic [12*N_SHOTS-1:0] shot_x_out, shot_y_out;

    modport master (
        output hcount_in, vcount_in, h_sync_in, v_sync_in, h_blank_in, v_blank_in,
        output rgb_in, x_pos_in, y_pos_in, left_click, hit_in,
        input  hcount_out, vcount_out, h_sync_out, v_sync_out, h_blank_out, v_blank_out,
        input  rgb_out, x_pos_out, y_pos_out, active_out, shot_x_out, shot_y_out
    );

    modport slave (
        input  hcount_in, vcount_in, h_sync_in, v_sync_in, h_blank_in, v_blank_in,
        input  rgb_in, x_pos_in, y_pos_in, left_click, hit_in,
        output hcount_out, vcount_out, h_sync_out, v_sync_out, h_blank_out, v_blank_out,
        output rgb_out, x_pos_out, y_pos_out, active_out, shot_x_out, shot_y_out
    );
endinterface

// File: rtl/strzal_multi.sv
// rtl/strzal_multi.sv - multi-slot Bresenham projectile overlay with 2-cycle pixel pipeline
// Ports: clk (pixel clock), rst (sync, active-high), bus (strzal_multi_if.slave):
//   timing/rgb/mouse inputs pass through with 2-cycle latency, rgb_out carries the overlay,
//   active_out flags slots in flight, shot_x_out/shot_y_out expose slot positions.
module strzal_multi #(
    parameter int          N_SHOTS = 4,
    parameter int          START_X = 400,
    parameter int          START_Y = 0,
    parameter int          SPEED   = 4,
    parameter int          SIZE    = 4,
    parameter int          H_RES   = 800,
    parameter int          V_RES   = 600,
    parameter logic [11:0] COLOR   = 12'hf00
) (
    input  logic          clk,
    input  logic          rst,
    strzal_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [11:0] ORG_X = 12'(START_X);
    localparam logic [11:0] ORG_Y = 12'(START_Y);

    state_t             state [N_SHOTS];
    logic [11:0]        pos_x [N_SHOTS];
    logic [11:0]        pos_y [N_SHOTS];
    logic [11:0]        dist_x [N_SHOTS];
    logic [11:0]        dist_y [N_SHOTS];
    logic signed [13:0] err [N_SHOTS];
    logic [N_SHOTS-1:0] neg_x, neg_y;
    // Slots that were already flying at the last frame tick; only these step in a burst.
    logic [N_SHOTS-1:0] armed;
    logic [3:0]         burst_cnt;
    logic               click_d;

    logic [10:0] hcount_d1, vcount_d1;
    logic        h_sync_d1, v_sync_d1, h_blank_d1, v_blank_d1;
    logic [11:0] rgb_d1, x_pos_d1, y_pos_d1;
    logic        inside_d1;

    logic               click_edge, tick, stepping, found, inside_any;
    logic [N_SHOTS-1:0] alloc_sel, exit_now;
    logic [11:0]        launch_dx, launch_dy, hx, vy;
    logic signed [15:0] e2 [N_SHOTS];
    logic signed [15:0] err_w [N_SHOTS];
    logic [11:0]        step_x [N_SHOTS];
    logic [11:0]        step_y [N_SHOTS];

    assign click_edge = bus.left_click & ~click_d;
    assign tick       = bus.v_blank_in & ~v_blank_d1;
    assign stepping   = (burst_cnt != 4'd0);
    assign launch_dx  = (bus.x_pos_in >= ORG_X) ? bus.x_pos_in - ORG_X : ORG_X - bus.x_pos_in;
    assign launch_dy  = (bus.y_pos_in >= ORG_Y) ? bus.y_pos_in - ORG_Y : ORG_Y - bus.y_pos_in;
    assign hx         = {1'b0, bus.hcount_in};
    assign vy         = {1'b0, bus.vcount_in};

    always_comb begin
        found      = 1'b0;
        alloc_sel  = '0;
        inside_any = 1'b0;
        exit_now   = '0;
        for (int i = 0; i < N_SHOTS; i++) begin
            if (!found && state[i] == IDLE) begin
                alloc_sel[i] = 1'b1;
                found        = 1'b1;
            end
            exit_now[i] = (pos_x[i] >= 12'(H_RES)) || (pos_y[i] >= 12'(V_RES)) || bus.hit_in[i];
            if (state[i] == FLY && hx >= pos_x[i] && hx < 12'(pos_x[i] + 12'(SIZE)) &&
                vy >= pos_y[i] && vy < 12'(pos_y[i] + 12'(SIZE)))
                inside_any = 1'b1;
            // One Bresenham step; both adjustments are decided from the same e2.
            e2[i]    = {err[i][13], err[i], 1'b0};
            err_w[i] = {{2{err[i][13]}}, err[i]};
            step_x[i] = pos_x[i];
            step_y[i] = pos_y[i];
            if (e2[i] + $signed({4'b0, dist_y[i]}) > 16'sd0) begin
                err_w[i]  = err_w[i] - $signed({4'b0, dist_y[i]});
                step_x[i] = neg_x[i] ? pos_x[i] - 12'd1 : pos_x[i] + 12'd1;
            end
            if (e2[i] < $signed({4'b0, dist_x[i]})) begin
                err_w[i]  = err_w[i] + $signed({4'b0, dist_x[i]});
                step_y[i] = neg_y[i] ? pos_y[i] - 12'd1 : pos_y[i] + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            click_d   <= 1'b0;
            burst_cnt <= 4'd0;
            armed     <= '0;
            neg_x     <= '0;
            neg_y     <= '0;
            for (int i = 0; i < N_SHOTS; i++) begin
                state[i]  <= IDLE;
                pos_x[i]  <= '0;
                pos_y[i]  <= '0;
                dist_x[i] <= '0;
                dist_y[i] <= '0;
                err[i]    <= '0;
            end
            hcount_d1 <= '0; vcount_d1 <= '0;
            h_sync_d1 <= 1'b0; v_sync_d1 <= 1'b0; h_blank_d1 <= 1'b0; v_blank_d1 <= 1'b0;
            rgb_d1 <= '0; x_pos_d1 <= '0; y_pos_d1 <= '0; inside_d1 <= 1'b0;
            bus.hcount_out <= '0; bus.vcount_out <= '0;
            bus.h_sync_out <= 1'b0; bus.v_sync_out <= 1'b0;
            bus.h_blank_out <= 1'b0; bus.v_blank_out <= 1'b0;
            bus.rgb_out <= '0; bus.x_pos_out <= '0; bus.y_pos_out <= '0;
            bus.active_out <= '0; bus.shot_x_out <= '0; bus.shot_y_out <= '0;
        end else begin
            click_d <= bus.left_click;

            hcount_d1  <= bus.hcount_in;  vcount_d1  <= bus.vcount_in;
            h_sync_d1  <= bus.h_sync_in;  v_sync_d1  <= bus.v_sync_in;
            h_blank_d1 <= bus.h_blank_in; v_blank_d1 <= bus.v_blank_in;
            rgb_d1     <= bus.rgb_in;     x_pos_d1   <= bus.x_pos_in;
            y_pos_d1   <= bus.y_pos_in;   inside_d1  <= inside_any;

            bus.hcount_out  <= hcount_d1;  bus.vcount_out  <= vcount_d1;
            bus.h_sync_out  <= h_sync_d1;  bus.v_sync_out  <= v_sync_d1;
            bus.h_blank_out <= h_blank_d1; bus.v_blank_out <= v_blank_d1;
            bus.x_pos_out   <= x_pos_d1;   bus.y_pos_out   <= y_pos_d1;
            bus.rgb_out     <= (inside_d1 && !h_blank_d1 && !v_blank_d1) ? COLOR : rgb_d1;

            if (tick)
                burst_cnt <= 4'(SPEED);
            else if (stepping)
                burst_cnt <= burst_cnt - 4'd1;

            for (int i = 0; i < N_SHOTS; i++) begin
                bus.active_out[i]       <= (state[i] == FLY);
                bus.shot_x_out[12*i +: 12] <= (state[i] == IDLE) ? 12'd0 : pos_x[i];
                bus.shot_y_out[12*i +: 12] <= (state[i] == IDLE) ? 12'd0 : pos_y[i];
                case (state[i])
                    IDLE: begin
                        if (click_edge && alloc_sel[i]) begin
                            pos_x[i]  <= ORG_X;
                            pos_y[i]  <= ORG_Y;
                            dist_x[i] <= launch_dx;
                            dist_y[i] <= launch_dy;
                            neg_x[i]  <= (bus.x_pos_in < ORG_X);
                            neg_y[i]  <= (bus.y_pos_in < ORG_Y);
                            err[i]    <= 14'($signed({2'b0, launch_dx}) - $signed({2'b0, launch_dy}));
                            armed[i]  <= 1'b0;
                            state[i]  <= (launch_dx == 12'd0 && launch_dy == 12'd0) ? DONE : FLY;
                        end
                    end
                    FLY: begin
                        if (exit_now[i]) begin
                            state[i] <= DONE;
                            armed[i] <= 1'b0;
                        end else begin
                            if (stepping && armed[i]) begin
                                pos_x[i] <= step_x[i];
                                pos_y[i] <= step_y[i];
                                err[i]   <= err_w[i][13:0];
                            end
                            if (tick)
                                armed[i] <= 1'b1;
                        end
                    end
                    default: begin
                        state[i]  <= IDLE;
                        pos_x[i]  <= '0;
                        pos_y[i]  <= '0;
                        dist_x[i] <= '0;
                        dist_y[i] <= '0;
                        err[i]    <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_strzal_multi.sv
// tb/tb_strzal_multi.sv - directed scoreboard bench for strzal_multi
module tb_strzal_multi;
    localparam int N = 4;
    localparam int SPEED = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    strzal_multi_if #(.N_SHOTS(N)) bus ();
    strzal_multi dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic [10:0] hc;
        logic [10:0] vc;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        while (sb.size() > 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            chk("rgb_out", 48'(bus.rgb_out), 48'(e.rgb));
            chk("hcount_out", 48'(bus.hcount_out), 48'(e.hc));
            chk("vcount_out", 48'(bus.vcount_out), 48'(e.vc));
        end
    endtask

    function automatic logic [11:0] slot_x(input int i);
        return bus.shot_x_out[12*i +: 12];
    endfunction

    function automatic logic [11:0] slot_y(input int i);
        return bus.shot_y_out[12*i +: 12];
    endfunction

    // Drive one pixel; its expected overlay result is due two edges later.
    task automatic px(input int h, input int v, input logic hb, input logic [11:0] exp_rgb);
        exp_t e;
        bus.hcount_in  = 11'(h);
        bus.vcount_in  = 11'(v);
        bus.h_blank_in = hb;
        e.due = cycle + 2;
        e.rgb = exp_rgb;
        e.hc  = 11'(h);
        e.vc  = 11'(v);
        sb.push_back(e);
        cyc();
    endtask

    task automatic drain();
        bus.h_blank_in = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic frame();
        bus.v_blank_in = 1'b1;
        repeat (SPEED + 3) cyc();
        bus.v_blank_in = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic click(input int mx, input int my);
        bus.x_pos_in   = 12'(mx);
        bus.y_pos_in   = 12'(my);
        bus.left_click = 1'b1;
        cyc();
        bus.left_click = 1'b0;
        cyc();
    endtask

    task automatic hit(input logic [N-1:0] m);
        bus.hit_in = m;
        cyc();
        bus.hit_in = '0;
        repeat (3) cyc();
    endtask

    initial begin
        bus.hcount_in = 11'd5; bus.vcount_in = 11'd5;
        bus.h_sync_in = 1'b1; bus.v_sync_in = 1'b1;
        bus.h_blank_in = 1'b0; bus.v_blank_in = 1'b0;
        bus.rgb_in = 12'h123; bus.x_pos_in = 12'd77; bus.y_pos_in = 12'd88;
        bus.left_click = 1'b0; bus.hit_in = '0;

        // Reset state
        repeat (2) cyc();
        chk("rst_rgb", 48'(bus.rgb_out), 48'h0);
        chk("rst_hcount", 48'(bus.hcount_out), 48'h0);
        chk("rst_active", 48'(bus.active_out), 48'h0);
        chk("rst_xpos", 48'(bus.x_pos_out), 48'h0);
        chk("rst_shotx", 48'(bus.shot_x_out), 48'h0);
        rst = 1'b0;
        bus.rgb_in = 12'h0a5;
        cyc();
        cyc();
        chk("xpos_delay", 48'(bus.x_pos_out), 48'd77);

        // Vertical shot
        click(400, 300);
        chk("vert_active", 48'(bus.active_out), 48'b0001);
        frame();
        chk("vert_x", 48'(slot_x(0)), 48'd400);
        chk("vert_y", 48'(slot_y(0)), 48'd4);
        px(400, 4, 1'b0, 12'hf00);
        px(403, 7, 1'b0, 12'hf00);
        px(404, 4, 1'b0, 12'h0a5);
        px(399, 5, 1'b0, 12'h0a5);
        px(401, 8, 1'b0, 12'h0a5);
        px(401, 3, 1'b0, 12'h0a5);
        px(401, 5, 1'b1, 12'h0a5);
        drain();
        hit(4'b0001);
        chk("vert_clr_act", 48'(bus.active_out), 48'h0);
        chk("vert_clr_y", 48'(slot_y(0)), 48'h0);

        // Diagonal, then negative x direction
        click(600, 200);
        frame();
        chk("diag1_x", 48'(slot_x(0)), 48'd404);
        chk("diag1_y", 48'(slot_y(0)), 48'd4);
        frame();
        chk("diag2_x", 48'(slot_x(0)), 48'd408);
        chk("diag2_y", 48'(slot_y(0)), 48'd8);
        hit(4'b0001);
        click(200, 200);
        frame();
        chk("neg_x", 48'(slot_x(0)), 48'd396);
        chk("neg_y", 48'(slot_y(0)), 48'd4);
        hit(4'b0001);

        // Allocation: five clicks, fifth dropped
        for (int k = 0; k < 5; k++) begin
            click(400, 300);
            frame();
        end
        chk("alloc_active", 48'(bus.active_out), 48'b1111);
        chk("alloc_y0", 48'(slot_y(0)), 48'd20);
        chk("alloc_y3", 48'(slot_y(3)), 48'd8);
        hit(4'b0010);
        chk("alloc_hit_act", 48'(bus.active_out), 48'b1101);
        chk("alloc_hit_y1", 48'(slot_y(1)), 48'd0);
        click(400, 300);
        chk("realloc_act", 48'(bus.active_out), 48'b1111);
        chk("realloc_x1", 48'(slot_x(1)), 48'd400);
        chk("realloc_y2", 48'(slot_y(2)), 48'd12);
        hit(4'b1111);
        chk("allclr_act", 48'(bus.active_out), 48'h0);

        // Off-screen exit after 100 frames
        click(799, 0);
        repeat (99) frame();
        chk("exit99_act", 48'(bus.active_out), 48'b0001);
        chk("exit99_x", 48'(slot_x(0)), 48'd796);
        frame();
        chk("exit100_act", 48'(bus.active_out), 48'h0);

        // Zero-length shot never flies
        bus.x_pos_in = 12'd400;
        bus.y_pos_in = 12'd0;
        bus.left_click = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("zero_act", 48'(bus.active_out), 48'h0);
        end
        bus.left_click = 1'b0;
        cyc();

        // Held click fires once
        bus.y_pos_in = 12'd300;
        bus.left_click = 1'b1;
        repeat (1000) cyc();
        bus.left_click = 1'b0;
        cyc();
        chk("held_act", 48'(bus.active_out), 48'b0001);
        frame();
        chk("held_y", 48'(slot_y(0)), 48'd4);

        // Hit in the first burst cycle discards the step
        bus.v_blank_in = 1'b1;
        cyc();
        bus.hit_in = 4'b0001;
        cyc();
        bus.hit_in = '0;
        cyc();
        chk("hitburst_y", 48'(slot_y(0)), 48'd4);
        chk("hitburst_act", 48'(bus.active_out), 48'h0);
        cyc();
        chk("hitburst_clr", 48'(slot_x(0)), 48'h0);
        repeat (3) cyc();
        bus.v_blank_in = 1'b0;
        repeat (3) cyc();

        // Click in the tick cycle: new slot waits a frame
        click(400, 300);
        frame();
        bus.left_click = 1'b1;
        bus.v_blank_in = 1'b1;
        cyc();
        bus.left_click = 1'b0;
        repeat (SPEED + 2) cyc();
        bus.v_blank_in = 1'b0;
        repeat (3) cyc();
        chk("tickclk_act", 48'(bus.active_out), 48'b0011);
        chk("tickclk_y1", 48'(slot_y(1)), 48'd0);
        chk("tickclk_x1", 48'(slot_x(1)), 48'd400);
        chk("tickclk_y0", 48'(slot_y(0)), 48'd8);
        frame();
        chk("tickclk2_y1", 48'(slot_y(1)), 48'd4);
        chk("tickclk2_y0", 48'(slot_y(0)), 48'd12);

        // Reset mid-flight
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_act", 48'(bus.active_out), 48'h0);
        chk("midrst_rgb", 48'(bus.rgb_out), 48'h0);
        chk("midrst_shot", 48'(bus.shot_y_out), 48'h0);
        frame();
        px(400, 16, 1'b0, 12'h0a5);
        px(400, 8, 1'b0, 12'h0a5);
        px(400, 4, 1'b0, 12'h0a5);
        drain();
        chk("midrst_act2", 48'(bus.active_out), 48'h0);
        chk("sb_empty", 48'(sb.size()), 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
